ahb_burst_addr_gen: RTL
=======================

Name: ahb_burst_addr_gen

Overview:
- Parametrised AHB master address-phase sequencer.
- Accepts one burst command per handshake from the master's transaction layer.
- Drives HADDR/HTRANS/HBURST/HSIZE/HWRITE for every beat of all eight HBURST encodings, including WRAP8/WRAP16 and undefined-length INCR.
- Supports wait states, master-inserted BUSY cycles, 1 KB boundary splitting of INCR, and rejection of illegal commands.

Parameters:
- ADDR_WIDTH, 32, HADDR and cmd_addr width.
- DATA_WIDTH, 32, bus data width; max legal HSIZE = log2(DATA_WIDTH/8).
- MAX_INCR_LEN, 16, max beats for undefined-length INCR; cmd_len range 1..MAX_INCR_LEN.
- BOUNDARY_BYTES, 1024, address boundary no burst may cross (power of 2).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  generator can accept a command.
- cmd_addr  in  ADDR_WIDTH  first-beat address.
- cmd_burst  in  3  HBURST encoding.
- cmd_size  in  3  HSIZE encoding.
- cmd_len  in  $clog2(MAX_INCR_LEN)+1  beat count; used only for INCR.
- cmd_write  in  1  write(1)/read(0).
- busy_req  in  1  request a BUSY cycle before the next beat.
- HREADY  in  1  previous transfer complete / address phase accepted.
- HADDR  out  ADDR_WIDTH  current beat address.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HBURST  out  3  burst type of current transfer.
- HSIZE  out  3  transfer size.
- HWRITE  out  1  direction.
- beat_done  out  1  pulse: NONSEQ/SEQ beat accepted (HREADY=1) this cycle.
- burst_done  out  1  pulse: cycle after last beat accepted.
- cmd_err  out  1  pulse: command rejected.

Behaviour:
- Reset (HRESETn=0 at a rising edge):
  - Outputs: HADDR=0, HTRANS=IDLE, HBURST=SINGLE, HSIZE=000, HWRITE=0, cmd_ready=0, all pulses 0.
  - Takes effect even mid-burst: burst abandoned, no further beats.
  - cmd_ready=1 in the first cycle after reset release.
- States: IDLE, ACTIVE, BUSY_ST. cmd_ready=1 only in IDLE.
- Command accepted when cmd_valid && cmd_ready.
- Legality checks at acceptance; on violation: cmd_err=1 next cycle, stay IDLE, no bus activity. Illegal when:
  - cmd_size > log2(DATA_WIDTH/8);
  - cmd_addr not aligned to 2^cmd_size;
  - INCR with cmd_len of 0 or > MAX_INCR_LEN;
  - INCR4/8/16 whose last byte crosses a BOUNDARY_BYTES boundary.
- Legal command: next cycle HTRANS=NONSEQ, HADDR=cmd_addr; HBURST/HSIZE/HWRITE latched for the whole burst; state=ACTIVE.
- Beat count: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=cmd_len.
- Beat accept: HTRANS in {NONSEQ,SEQ} && HREADY=1. While HREADY=0, all outputs hold exactly.
- Next address, with sb = 2^HSIZE:
  - INCR*: addr + sb.
  - WRAPn: wb = n*sb; (addr & ~(wb-1)) | ((addr+sb) & (wb-1)).
- INCR crossing BOUNDARY_BYTES: the first beat at the new boundary is driven as NONSEQ with HBURST=INCR; remaining beats SEQ.
- BUSY:
  - If busy_req=1 in a cycle where a non-last beat is accepted, next cycle HTRANS=BUSY with HADDR = next beat address (state BUSY_ST).
  - Stay in BUSY while busy_req=1; return to SEQ with the same address the cycle after busy_req=0.
  - busy_req ignored on the last beat and in IDLE.
- After last beat accepted:
  - Next cycle: HTRANS=IDLE, burst_done=1, state=IDLE, cmd_ready=1.
  - Minimum one IDLE cycle between bursts.
  - HADDR/HBURST/HSIZE/HWRITE hold their last values during IDLE.
- SINGLE: one NONSEQ beat, then IDLE.

Test Plan:
- WRAP4 WORD at 0x38, HREADY=1 -> HADDR 0x38,0x3C,0x30,0x34; HTRANS NONSEQ,SEQ,SEQ,SEQ; 4 beat_done pulses; burst_done on the following IDLE cycle.
- WRAP8 HALF_WORD at 0x1006 -> HADDR 0x1006,0x1008,0x100A,0x100C,0x100E,0x1000,0x1002,0x1004.
- INCR cmd_len=4 WORD at 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ; HBURST=INCR throughout.
- INCR4 WORD at 0x100:
  - HREADY=0 for 2 cycles on beat 2 -> HADDR=0x104/SEQ held 3 cycles.
  - busy_req=1 for 1 cycle at beat-2 accept -> BUSY at HADDR 0x108, then SEQ 0x108.
- Illegal commands -> cmd_err pulse, HTRANS stays IDLE, cmd_ready stays 1:
  - INCR16 WORD at 0x3F0;
  - WORD at 0x102;
  - HSIZE=011 with DATA_WIDTH=32.
- HRESETn=0 during beat 3 of INCR8 -> next cycle HTRANS=IDLE, HADDR=0, cmd_ready=0; after release, a new SINGLE at 0x20 issues NONSEQ 0x20.

Source files
------------

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: AHB master address-phase sequencer for all HBURST types
module ahb_burst_addr_gen #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_INCR_LEN   = 16,
  parameter int BOUNDARY_BYTES = 1024
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [2:0]                    cmd_burst,
  input  logic [2:0]                    cmd_size,
  input  logic [$clog2(MAX_INCR_LEN):0] cmd_len,
  input  logic                          cmd_write,
  input  logic                          busy_req,
  input  logic                          HREADY,
  output logic [ADDR_WIDTH-1:0]         HADDR,
  output logic [1:0]                    HTRANS,
  output logic [2:0]                    HBURST,
  output logic [2:0]                    HSIZE,
  output logic                          HWRITE,
  output logic                          beat_done,
  output logic                          burst_done,
  output logic                          cmd_err
);
  localparam int LW       = $clog2(MAX_INCR_LEN) + 1;
  localparam int CW       = LW > 5 ? LW : 5;
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int BW       = $clog2(BOUNDARY_BYTES);
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BUSY} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cmd_beats;
  logic [CW-1:0]         cur_beats;
  logic [31:0]           cmd_span;
  logic                  illegal;
  logic                  is_wrap;
  logic [ADDR_WIDTH-1:0] sb;
  logic [ADDR_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0] nxt;
  logic [1:0]            nxt_trans;
  logic [1:0]            cur_trans;
  function automatic logic [CW-1:0] fixed_beats(input logic [2:0] b);
    return b[2:1] == 2'd1 ? CW'(4) : b[2:1] == 2'd2 ? CW'(8) : b[2:1] == 2'd3 ? CW'(16) : CW'(1);
  endfunction
  function automatic logic [1:0] beat_trans(input logic [2:0] b, input logic [ADDR_WIDTH-1:0] a);
    return (b == B_INCR && a[BW-1:0] == '0) ? T_NSEQ : T_SEQ;
  endfunction
  // command legality and next-beat address/transfer type
  always_comb begin
    cmd_beats = cmd_burst == B_INCR ? CW'(cmd_len) : fixed_beats(cmd_burst);
    cmd_span  = 32'(cmd_addr[BW-1:0]) + (32'(cmd_beats) << cmd_size);
    illegal   = cmd_size > 3'(MAX_SIZE)
             || |(cmd_addr & ((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1)))
             || (cmd_burst == B_INCR && (cmd_len == '0 || cmd_len > LW'(MAX_INCR_LEN)))
             || (cmd_burst[0] && cmd_burst != B_INCR && cmd_span > 32'(BOUNDARY_BYTES));
    sb        = ADDR_WIDTH'(1) << HSIZE;
    cur_beats = fixed_beats(HBURST);
    wmask     = (ADDR_WIDTH'(cur_beats) << HSIZE) - ADDR_WIDTH'(1);
    is_wrap   = !HBURST[0] && HBURST != B_SINGLE;
    nxt       = is_wrap ? (HADDR & ~wmask) | ((HADDR + sb) & wmask) : HADDR + sb;
    nxt_trans = beat_trans(HBURST, nxt);
    cur_trans = beat_trans(HBURST, HADDR);
  end
  assign beat_done = HTRANS[1] & HREADY;
  // burst sequencer: command acceptance, beat stepping, BUSY insertion
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      HADDR      <= '0;
      HTRANS     <= T_IDLE;
      HBURST     <= B_SINGLE;
      HSIZE      <= 3'b000;
      HWRITE     <= 1'b0;
      burst_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      cmd_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (illegal) begin
              cmd_err <= 1'b1;
            end else begin
              state     <= S_ACTIVE;
              cmd_ready <= 1'b0;
              HTRANS    <= T_NSEQ;
              HADDR     <= cmd_addr;
              HBURST    <= cmd_burst;
              HSIZE     <= cmd_size;
              HWRITE    <= cmd_write;
              cnt       <= cmd_beats - CW'(1);
            end
          end
        end
        S_ACTIVE: begin
          if (HREADY) begin
            if (cnt == '0) begin
              state      <= S_IDLE;
              HTRANS     <= T_IDLE;
              burst_done <= 1'b1;
              cmd_ready  <= 1'b1;
            end else begin
              HADDR  <= nxt;
              cnt    <= cnt - CW'(1);
              state  <= busy_req ? S_BUSY : S_ACTIVE;
              HTRANS <= busy_req ? T_BUSY : nxt_trans;
            end
          end
        end
        S_BUSY: begin
          if (HREADY && !busy_req) begin
            state  <= S_ACTIVE;
            HTRANS <= cur_trans;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
